// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;

  // One buffered fetch result: the instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_sync_fifo.sv
// Small synchronous FIFO with synchronous clear.
// Push and pop may happen together in the same cycle at any occupancy.
// data_o always shows the head entry. It is meaningful only while empty_o is low.
module inst_fetch_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot that a simultaneous push into a full FIFO needs.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping. The pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage array. It has no reset because the pointers gate what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && !clear_i) |-> (!full_o || pop_i));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop_i && !clear_i) |-> !empty_o);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage. It issues the PC on a req/gnt bus and keeps several reads in flight.
// In-order responses are buffered and presented to ID through a registered output.
// A taken jump flushes everything on the wrong path. Reads already in flight are counted and dropped.
// Handshake: a request is accepted on a cycle where ibus_req_o and ibus_gnt_i are both high.
// ibus_rvalid_i carries one response per cycle, in issue order, and cannot be back-pressured.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic [31:0] pc_addr_i,
  input  logic        jump_ena_i,
  input  logic        hold_ena_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic        stall_req_o
);

  localparam int OCW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int OCCW = FCW + 1;

  logic            flush, issue, accept, load, bypass;
  logic [OCW-1:0]  out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [OCCW-1:0] occupancy;

  logic [31:0]     head_tag;
  logic            tag_full, tag_empty;
  logic [FCW-1:0]  tag_cnt;

  fetch_entry_t    head_entry;
  logic [63:0]     head_raw;
  logic            data_full, data_empty, data_push, data_pop;
  logic [FCW-1:0]  data_cnt;

  logic [31:0]     inst_q, inst_d, inst_addr_q, inst_addr_d;
  logic            inst_valid_q, inst_valid_d;

  // Hold beats jump, which is the same priority the PC register uses.
  assign flush     = jump_ena_i & ~hold_ena_i;
  assign occupancy = OCCW'(out_cnt_q) + OCCW'(data_cnt);

  // Credit check: every outstanding read must already have a FIFO slot reserved.
  assign ibus_req_o  = ~flush & ~hold_ena_i
                     & (occupancy < OCCW'(FIFO_DEPTH))
                     & (out_cnt_q < OCW'(MAX_OUTSTANDING));
  assign ibus_addr_o = pc_addr_i;
  assign issue       = ibus_req_o & ibus_gnt_i;
  assign stall_req_o = ~issue & ~flush;

  // A response is kept only when it is not a wrong-path leftover.
  assign accept    = ibus_rvalid_i & ~flush & (drop_cnt_q == '0);
  assign load      = ~hold_ena_i & ~flush;
  assign bypass    = load & data_empty & accept;
  assign data_push = accept & ~bypass;
  assign data_pop  = load & ~data_empty;

  assign head_entry = fetch_entry_t'(head_raw);

  inst_fetch_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk_i   (clk_100MHz),
    .rst_ni  (arst_n),
    .push_i  (issue),
    .pop_i   (accept),
    .clear_i (flush),
    .data_i  (pc_addr_i),
    .data_o  (head_tag),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  inst_fetch_sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk_i   (clk_100MHz),
    .rst_ni  (arst_n),
    .push_i  (data_push),
    .pop_i   (data_pop),
    .clear_i (flush),
    .data_i  ({head_tag, ibus_rdata_i}),
    .data_o  (head_raw),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_cnt)
  );

  // Next values of the outstanding-read and wrong-path-drop counters.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue)         out_cnt_d = out_cnt_d + OCW'(1);
    if (ibus_rvalid_i) out_cnt_d = out_cnt_d - OCW'(1);
    drop_cnt_d = drop_cnt_q;
    if (flush)                                   drop_cnt_d = out_cnt_q - OCW'(ibus_rvalid_i);
    else if (ibus_rvalid_i && drop_cnt_q != '0)  drop_cnt_d = drop_cnt_q - OCW'(1);
  end

  // Register the read counters.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Select what the IF/ID output shows next: FIFO head first, then the bypassed response, else a bubble.
  always_comb begin
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
    if (flush) begin
      inst_d       = INST_NOP;
      inst_valid_d = 1'b0;
    end else if (!hold_ena_i) begin
      if (!data_empty) begin
        inst_d       = head_entry.data;
        inst_addr_d  = head_entry.addr;
        inst_valid_d = 1'b1;
      end else if (accept) begin
        inst_d       = ibus_rdata_i;
        inst_addr_d  = head_tag;
        inst_valid_d = 1'b1;
      end else begin
        inst_d       = INST_NOP;
        inst_valid_d = 1'b0;
      end
    end
  end

  // Register the IF/ID output.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      inst_q       <= INST_NOP;
      inst_addr_q  <= CPU_RESET_ADDR;
      inst_valid_q <= 1'b0;
    end else begin
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;

  a_rvalid_expected: assert property (@(posedge clk_100MHz) disable iff (!arst_n)
    ibus_rvalid_i |-> (out_cnt_q != '0));
  a_tag_available: assert property (@(posedge clk_100MHz) disable iff (!arst_n)
    accept |-> !tag_empty);
  a_tag_room: assert property (@(posedge clk_100MHz) disable iff (!arst_n)
    issue |-> (!tag_full || accept));
  a_data_room: assert property (@(posedge clk_100MHz) disable iff (!arst_n)
    data_push |-> (!data_full || data_pop));
  a_tag_balance: assert property (@(posedge clk_100MHz) disable iff (!arst_n)
    (OCCW'(tag_cnt) + OCCW'(drop_cnt_q)) == OCCW'(out_cnt_q));

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch.
// The bench plays the roles of the ctrl/PC logic and of an in-order instruction memory with random latency.
// The expected stream of delivered addresses is kept as a queue.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUT    = 2;
  localparam int N_PH       = 7;

  // ---------------- clock / reset ----------------
  logic        clk_100MHz = 1'b0;
  logic        arst_n     = 1'b1;
  always #5 clk_100MHz = ~clk_100MHz;

  logic [31:0] pc_addr_i;
  logic        jump_ena_i, hold_ena_i, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        ibus_req_o, inst_valid_o, stall_req_o;
  logic [31:0] ibus_addr_o, inst_o, inst_addr_o;

  inst_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_100MHz    (clk_100MHz),
    .arst_n        (arst_n),
    .pc_addr_i     (pc_addr_i),
    .jump_ena_i    (jump_ena_i),
    .hold_ena_i    (hold_ena_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o),
    .stall_req_o   (stall_req_o)
  );

  // ---------------- scoreboard state ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];   // granted addresses not yet delivered to ID and not flushed
  logic [31:0] bus_q[$];   // reads the memory model still owes a response for
  logic [31:0] pc, target;
  logic        flush_s, req_s;
  logic [31:0] prev_inst, prev_addr;
  logic        prev_valid;
  int          gnt_pct, rv_pct, jmp_pct, hold_pct;

  // Phase table: cycles, gnt %, rvalid %, jump %, hold %
  int ph_cyc [N_PH] = '{20, 40, 12, 30, 120, 120, 300};
  int ph_gnt [N_PH] = '{100, 50, 100, 100, 80, 80, 70};
  int ph_rv  [N_PH] = '{100, 60, 0, 100, 70, 70, 60};
  int ph_jmp [N_PH] = '{0, 0, 0, 0, 12, 0, 8};
  int ph_hold[N_PH] = '{0, 0, 0, 0, 0, 25, 15};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic save_prev();
    prev_inst  = inst_o;
    prev_addr  = inst_addr_o;
    prev_valid = inst_valid_o;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. It drives one cycle, checks the combinational outputs, advances the model at the edge,
  // then checks the registered outputs.
  task automatic step();
    hold_ena_i = (int'($urandom_range(0, 99)) < hold_pct);
    jump_ena_i = (int'($urandom_range(0, 99)) < jmp_pct);
    ibus_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    target     = 32'($urandom_range(64, 1023)) << 2;
    if (bus_q.size() > 0 && int'($urandom_range(0, 99)) < rv_pct) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = mem_word(bus_q[0]);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
    end
    pc_addr_i = pc;
    flush_s   = jump_ena_i & ~hold_ena_i;
    #3;
    req_s = ibus_req_o;
    chk("ibus_addr", ibus_addr_o, pc);
    chk("stall", {31'b0, stall_req_o}, {31'b0, ~(req_s & ibus_gnt_i) & ~flush_s});
    if (hold_ena_i || flush_s) chk("req_blocked", {31'b0, req_s}, 32'd0);
    if (bus_q.size() >= MAX_OUT) chk("credit", {31'b0, req_s}, 32'd0);
    if (!hold_ena_i && !flush_s && bus_q.size() == 0 && exp_q.size() == 0)
      chk("req_idle", {31'b0, req_s}, 32'd1);

    @(posedge clk_100MHz);
    if (ibus_rvalid_i) void'(bus_q.pop_front());
    if (req_s && ibus_gnt_i) begin
      bus_q.push_back(pc);
      exp_q.push_back(pc);
    end
    if (flush_s) begin
      exp_q.delete();
      pc = target;
    end else if (req_s && ibus_gnt_i) begin
      pc = pc + 32'd4;
    end
    #1;

    if (hold_ena_i) begin
      chk("hold_inst", inst_o, prev_inst);
      chk("hold_addr", inst_addr_o, prev_addr);
      chk("hold_valid", {31'b0, inst_valid_o}, {31'b0, prev_valid});
    end else if (flush_s) begin
      chk("flush_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("flush_nop", inst_o, INST_NOP);
    end else if (inst_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'b0, inst_valid_o}, 32'd0);
      end else begin
        logic [31:0] a;
        a = exp_q.pop_front();
        chk("inst_addr", inst_addr_o, a);
        chk("inst_data", inst_o, mem_word(a));
      end
    end else begin
      chk("bubble_nop", inst_o, INST_NOP);
    end
    save_prev();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inst"}, inst_o, INST_NOP);
    chk({tag, "_addr"}, inst_addr_o, CPU_RESET_ADDR);
    chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
  endtask

  task automatic drive_idle();
    jump_ena_i    = 1'b0;
    hold_ena_i    = 1'b0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    pc        = CPU_RESET_ADDR;
    pc_addr_i = pc;
    drive_idle();
    #1 arst_n = 1'b0;
    #2;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk_100MHz);
    #1 arst_n = 1'b1;
    @(posedge clk_100MHz);
    #1;
    check_reset_outputs("post_rst");
    save_prev();

    for (int p = 0; p < N_PH; p++) begin
      gnt_pct  = ph_gnt[p];
      rv_pct   = ph_rv[p];
      jmp_pct  = ph_jmp[p];
      hold_pct = ph_hold[p];
      for (int c = 0; c < ph_cyc[p]; c++) step();

      if (p == 5) begin
        // Asynchronous reset pulse in the middle of traffic.
        #2 arst_n = 1'b0;
        drive_idle();
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        bus_q.delete();
        pc        = CPU_RESET_ADDR;
        pc_addr_i = pc;
        #1;
        chk("mid_rst_req", {31'b0, ibus_req_o}, 32'd1);
        @(posedge clk_100MHz);
        #1 arst_n = 1'b1;
        save_prev();
      end
    end

    // Drain: no new grants. All owed responses return and every expected word must appear.
    gnt_pct  = 0;
    rv_pct   = 100;
    jmp_pct  = 0;
    hold_pct = 0;
    budget   = 50;
    while ((exp_q.size() > 0 || bus_q.size() > 0) && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    chk("drain_bus", bus_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
